bit_deserializer: RTL and testbench

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

---
 rtl/deser_pkg.sv | 14 +
 rtl/deser_out_reg.sv | 34 +++
 rtl/bit_deserializer.sv | 123 ++++++++++++
 tb/tb_bit_deserializer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial bit deserializer.
// Defining BIT_DESER_PARITY_EN adds the PARITY state used by the parity build.
package deser_pkg;

    `ifdef BIT_DESER_PARITY_EN
    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;
    `else
    typedef enum logic [1:0] {HUNT, DATA} state_t;
    `endif

    localparam logic [7:0] DEF_SYNC_WORD   = 8'hA5;
    localparam int         DEF_FRAME_WORDS = 4;

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry output holding register with a valid/ready handshake.
// It flags a drop when a new word arrives while the held word is stalled.
module deser_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop
);

    logic free;

    // The slot can take a new word when it is empty or being drained this cycle.
    assign free = !out_valid || out_ready;
    assign drop = load && !free;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load && free) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer: hunts for SYNC_WORD, then assembles FRAME_WORDS
// MSB-first words. Defining BIT_DESER_PARITY_EN adds an even-parity bit after each word.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(DEF_SYNC_WORD),
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              in_sync,
    output logic              overflow,
    output logic              parity_err
);

    localparam int CW = $clog2(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_nxt;
    logic [DATA_W:0]   shift_ext;
    logic [CW-1:0]     bit_cnt;
    logic [7:0]        word_cnt;
    logic              last_bit;
    logic              word_done;
    logic              frame_end;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              drop;

    assign shift_ext = {shreg, bit_in};
    assign shift_nxt = shift_ext[DATA_W-1:0];
    assign last_bit  = bit_valid && (state == DATA) && (bit_cnt == CW'(DATA_W - 1));
    assign frame_end = (word_cnt == 8'(FRAME_WORDS - 1));

`ifdef BIT_DESER_PARITY_EN
    logic par_ok;

    // Even parity across the word and its parity bit: total XOR must be zero.
    assign par_ok    = ~^shift_ext;
    assign word_done = bit_valid && (state == PARITY);
    assign load      = word_done && par_ok;
    assign load_data = shreg;

    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= word_done && !par_ok;
    end
`else
    assign word_done  = last_bit;
    assign load       = last_bit;
    assign load_data  = shift_nxt;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            in_sync  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        shreg <= shift_nxt;
                        if (shift_nxt == SYNC_WORD) begin
                            state    <= DATA;
                            in_sync  <= 1'b1;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= shift_nxt;
                        if (last_bit) begin
                            bit_cnt <= '0;
`ifdef BIT_DESER_PARITY_EN
                            state   <= PARITY;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
                // Shared word accounting; overrides the shifts above at frame end.
                if (word_done) begin
                    if (frame_end) begin
                        state    <= HUNT;
                        in_sync  <= 1'b0;
                        shreg    <= '0;
                        word_cnt <= '0;
                    end else begin
                        state    <= DATA;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
            end
        end
    end

    deser_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop)
    );

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed scoreboard bench for bit_deserializer; the parity scenario runs
// only when BIT_DESER_PARITY_EN is defined.
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       in_sync;
    logic       overflow;
    logic       parity_err;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    logic [7:0] exp_q[$];

    bit_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_sync    (in_sync),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Transfers happen at the next posedge; observe them half a cycle early.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [7:0] e;
            checks++;
            xfers++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected: got %h, scoreboard empty", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL xfer_data: got %h expected %h", out_data, e);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic v);
        bit_in = b;
        bit_valid = v;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s_drained: %0d words still expected, 0 required", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_data, out_valid, in_sync, overflow, parity_err} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: data=%h v=%b sync=%b ovf=%b perr=%b, all 0 required",
                     out_data, out_valid, in_sync, overflow, parity_err);
        end
    endtask

    task automatic test_sync_word();
        do_reset();
        out_ready = 1'b1;
        send_byte(8'hA5);
        checks++;
        if (in_sync !== 1'b1) begin
            failures++;
            $display("FAIL sync_in_sync: got %b expected 1", in_sync);
        end
        exp_q.push_back(8'h3C);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i), 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sync_early_valid: got %b expected 0", out_valid);
        end
        send_bit(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            failures++;
            $display("FAIL sync_word_out: v=%b data=%h expected v=1 data=3c", out_valid, out_data);
        end
        idle(2);
        check_drained("sync");
    endtask

    task automatic test_frame();
        int x0;
        do_reset();
        out_ready = 1'b1;
        x0 = xfers;
        send_byte(8'hA5);
        for (int w = 1; w <= 4; w++) begin
            exp_q.push_back(8'(w));
            send_byte(8'(w));
        end
        checks++;
        if (in_sync !== 1'b0) begin
            failures++;
            $display("FAIL frame_end_sync: got %b expected 0", in_sync);
        end
        idle(2);
        checks++;
        if (xfers - x0 !== 4) begin
            failures++;
            $display("FAIL frame_xfers: got %0d expected 4", xfers - x0);
        end
        send_byte(8'h11);
        idle(2);
        checks++;
        if (out_valid !== 1'b0 || xfers - x0 !== 4) begin
            failures++;
            $display("FAIL frame_hunt_ignore: v=%b xfers=%0d expected v=0 xfers=4", out_valid, xfers - x0);
        end
        send_byte(8'hA5);
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        idle(2);
        check_drained("frame");
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'hA5);
        exp_q.push_back(8'h55);
        send_byte(8'h55);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold: v=%b data=%h ovf=%b expected 1 55 0", out_valid, out_data, overflow);
        end
        send_byte(8'hAA);
        checks++;
        if (out_data !== 8'h55 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: data=%h ovf=%b expected 55 1", out_data, overflow);
        end
        out_ready = 1'b1;
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: v=%b ovf=%b expected 0 1", out_valid, overflow);
        end
        check_drained("ovf");
    endtask

    task automatic test_valid_toggle();
        logic [7:0] d;
        d = 8'h0F;
        do_reset();
        out_ready = 1'b1;
        send_byte(8'hA5);
        exp_q.push_back(d);
        for (int i = 7; i >= 1; i--) begin
            send_bit(d[i], 1'b1);
            send_bit(~d[i], 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL toggle_early_valid: got %b expected 0", out_valid);
        end
        send_bit(d[0], 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            failures++;
            $display("FAIL toggle_word: v=%b data=%h expected v=1 data=0f", out_valid, out_data);
        end
        idle(2);
        check_drained("toggle");
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h5A);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            failures++;
            $display("FAIL rstmid_held: v=%b data=%h expected 1 5a", out_valid, out_data);
        end
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if ({out_data, out_valid, in_sync, overflow, parity_err} !== 12'h000) begin
            failures++;
            $display("FAIL rstmid_outputs: data=%h v=%b sync=%b ovf=%b perr=%b, all 0 required",
                     out_data, out_valid, in_sync, overflow, parity_err);
        end
        out_ready = 1'b1;
        send_byte(8'hA5);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
            failures++;
            $display("FAIL rstmid_resync: v=%b data=%h expected 1 c3", out_valid, out_data);
        end
        idle(2);
        check_drained("rstmid");
    endtask

`ifdef BIT_DESER_PARITY_EN
    task automatic test_parity();
        do_reset();
        out_ready = 1'b1;
        send_byte(8'hA5);
        exp_q.push_back(8'h07);
        send_byte(8'h07);
        send_bit(1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h07 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL par_good: v=%b data=%h perr=%b expected 1 07 0", out_valid, out_data, parity_err);
        end
        idle(1);
        send_byte(8'h07);
        send_bit(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || parity_err !== 1'b1) begin
            failures++;
            $display("FAIL par_bad: v=%b perr=%b expected 0 1", out_valid, parity_err);
        end
        idle(1);
        checks++;
        if (parity_err !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL par_pulse: perr=%b v=%b expected 0 0", parity_err, out_valid);
        end
        idle(1);
        check_drained("par");
    endtask
`endif

    initial begin
        test_reset();
        test_sync_word();
        test_frame();
        test_overflow();
        test_valid_toggle();
        test_reset_mid();
`ifdef BIT_DESER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
